// File: rtl/snake_head_ctrl.sv
// ---------------------------------------------------------------------------
// snake_head_ctrl
//   Head controller for a grid snake game on a 32x32 torus (or walled grid).
//   Owns the game FSM (IDLE/RUN/OVER), the movement step timer, the current
//   and pending direction, and the head / previous-head coordinates.
//
//   Optional feature macro: SNAKE_WALL_DEATH_EN
//     undefined : coordinates wrap modulo 32, the border never ends the game
//     defined   : a step that would leave the grid ends the game instead
//
// Parameters
//   STEP_DIV  clocks per movement step (2..16_777_215)
//   START_X   head X after reset / restart
//   START_Y   head Y after reset / restart
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      starts a game from IDLE, returns OVER to IDLE
//   dir_valid  qualifies dir_in for one cycle
//   dir_in     00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
//   collision  OR of all body segment game_over outputs
//   head_x/y   current head coordinate
//   prev_x/y   head coordinate before the last step
//   step_en    one-cycle strobe following each step
//   state      00 IDLE, 01 RUN, 10 OVER (FSM state, also for debug)
//   game_over  high exactly while state is OVER
//
// Handshake: dir_valid is a single-cycle qualifier with no back-pressure;
// a request is taken on every edge where dir_valid is high and the FSM is
// not in OVER. Non-reversal requests overwrite the pending direction, so the
// last one before a step wins; one arriving on the step edge itself still
// steers that step.
// ---------------------------------------------------------------------------
module snake_head_ctrl #(
    parameter int unsigned STEP_DIV = 12_500_000,
    parameter int unsigned START_X  = 16,
    parameter int unsigned START_Y  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dir_valid,
    input  logic [1:0] dir_in,
    input  logic       collision,
    output logic [4:0] head_x,
    output logic [4:0] head_y,
    output logic [4:0] prev_x,
    output logic [4:0] prev_y,
    output logic       step_en,
    output logic [1:0] state,
    output logic       game_over
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_OVER = 2'b10;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [4:0]  SX      = START_X[4:0];
    localparam logic [4:0]  SY      = START_Y[4:0];
    localparam logic [4:0]  SX_PREV = SX - 5'd1;
    localparam logic [23:0] CNT_MAX = 24'(STEP_DIV - 1);

    logic [23:0] cnt;
    logic [1:0]  cur_dir;
    logic [1:0]  pend_dir;

    logic        dir_req_ok;
    logic [1:0]  eff_dir;
    logic        step_due;
    logic        wall_hit;
    logic [4:0]  nxt_x;
    logic [4:0]  nxt_y;

    // Opposite directions share the axis bit [1] and differ in bit [0].
    assign dir_req_ok = dir_valid && (state != ST_OVER) &&
                        !((dir_in[1] == cur_dir[1]) && (dir_in[0] != cur_dir[0]));

    // Direction used if a step happens this edge: a same-edge request applies.
    assign eff_dir  = dir_req_ok ? dir_in : pend_dir;

    // Collision suppresses any step scheduled on the same edge.
    assign step_due = (state == ST_RUN) && (cnt == CNT_MAX) && !collision;

    always_comb begin
        nxt_x = head_x;
        nxt_y = head_y;
        case (eff_dir)
            DIR_UP:    nxt_y = head_y - 5'd1;
            DIR_DOWN:  nxt_y = head_y + 5'd1;
            DIR_LEFT:  nxt_x = head_x - 5'd1;
            default:   nxt_x = head_x + 5'd1;
        endcase
    end

`ifdef SNAKE_WALL_DEATH_EN
    always_comb begin
        wall_hit = 1'b0;
        case (eff_dir)
            DIR_UP:    wall_hit = (head_y == 5'd0);
            DIR_DOWN:  wall_hit = (head_y == 5'd31);
            DIR_LEFT:  wall_hit = (head_x == 5'd0);
            default:   wall_hit = (head_x == 5'd31);
        endcase
    end
`else
    assign wall_hit = 1'b0;
`endif

    assign game_over = (state == ST_OVER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= 24'd0;
            head_x   <= SX;
            head_y   <= SY;
            prev_x   <= SX_PREV;
            prev_y   <= SY;
            cur_dir  <= DIR_RIGHT;
            pend_dir <= DIR_RIGHT;
            step_en  <= 1'b0;
        end else begin
            step_en <= 1'b0;
            if (dir_req_ok) begin
                pend_dir <= dir_in;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        cnt   <= 24'd0;
                    end
                end
                ST_RUN: begin
                    if (collision) begin
                        state <= ST_OVER;
                    end else if (step_due) begin
                        cnt <= 24'd0;
                        if (wall_hit) begin
                            state <= ST_OVER;
                        end else begin
                            cur_dir <= eff_dir;
                            prev_x  <= head_x;
                            prev_y  <= head_y;
                            head_x  <= nxt_x;
                            head_y  <= nxt_y;
                            step_en <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        state    <= ST_IDLE;
                        head_x   <= SX;
                        head_y   <= SY;
                        prev_x   <= SX_PREV;
                        prev_y   <= SY;
                        cur_dir  <= DIR_RIGHT;
                        pend_dir <= DIR_RIGHT;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_head_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snake_head_ctrl
//   Self-checking bench for snake_head_ctrl (default build, wrap-around).
//   A cycle-level reference model tracks the game as plain integers:
//   game phase, cycles into the current step period, head/prev position on
//   a 32x32 torus, and the steering direction.
// ---------------------------------------------------------------------------
module tb_snake_head_ctrl;

    localparam int STEP_DIV = 4;
    localparam int SX = 16;
    localparam int SY = 16;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       dir_valid;
    logic [1:0] dir_in;
    logic       collision;
    logic [4:0] head_x;
    logic [4:0] head_y;
    logic [4:0] prev_x;
    logic [4:0] prev_y;
    logic       step_en;
    logic [1:0] state;
    logic       game_over;

    snake_head_ctrl #(
        .STEP_DIV (STEP_DIV),
        .START_X  (SX),
        .START_Y  (SY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dir_valid (dir_valid),
        .dir_in    (dir_in),
        .collision (collision),
        .head_x    (head_x),
        .head_y    (head_y),
        .prev_x    (prev_x),
        .prev_y    (prev_y),
        .step_en   (step_en),
        .state     (state),
        .game_over (game_over)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 run, 2 over; tick = cycles elapsed in current period
    int m_phase, m_tick, m_hx, m_hy, m_px, m_py, m_dir, m_pend, m_step;
    int steps_seen;

    function automatic bit opposite(input int a, input int b);
        return (a / 2 == b / 2) && (a != b);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_tick = 0;
        m_hx = SX; m_hy = SY; m_px = SX - 1; m_py = SY;
        m_dir = 3; m_pend = 3; m_step = 0;
    endtask

    task automatic compare_all();
        check_eq("state",     int'(state),     m_phase);
        check_eq("game_over", int'(game_over), (m_phase == 2) ? 1 : 0);
        check_eq("step_en",   int'(step_en),   m_step);
        check_eq("head_x",    int'(head_x),    m_hx);
        check_eq("head_y",    int'(head_y),    m_hy);
        check_eq("prev_x",    int'(prev_x),    m_px);
        check_eq("prev_y",    int'(prev_y),    m_py);
    endtask

    // One clock: inputs applied at negedge, model advanced, DUT checked at next negedge.
    task automatic cycle(input bit s, input bit dv, input int d, input bit col);
        int steer;
        start = s; dir_valid = dv; dir_in = 2'(d); collision = col;
        m_step = 0;
        steer = (dv && m_phase != 2 && !opposite(d, m_dir)) ? d : m_pend;
        case (m_phase)
            0: begin
                m_pend = steer;
                if (s) begin m_phase = 1; m_tick = 0; end
            end
            1: begin
                m_pend = steer;
                if (col) m_phase = 2;
                else if (m_tick == STEP_DIV - 1) begin
                    m_tick = 0;
                    m_dir = steer;
                    m_px = m_hx; m_py = m_hy;
                    case (steer)
                        0: m_hy = (m_hy + 31) % 32;
                        1: m_hy = (m_hy + 1) % 32;
                        2: m_hx = (m_hx + 31) % 32;
                        default: m_hx = (m_hx + 1) % 32;
                    endcase
                    m_step = 1;
                end else m_tick++;
            end
            default: begin
                if (s) begin
                    model_reset();
                end
            end
        endcase
        @(posedge clk);
        @(negedge clk);
        if (m_step) steps_seen++;
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    // Run quietly until the model reports a step; bounded.
    task automatic wait_step();
        int k;
        k = 0;
        do begin
            cycle(0, 0, 0, 0);
            k++;
        end while (!m_step && k < 3 * STEP_DIV);
        if (!m_step) check_eq("wait_step_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        steps_seen = 0;
        rst_n = 1'b0; start = 0; dir_valid = 0; dir_in = 2'd0; collision = 0;
        model_reset();
        @(negedge clk);
        compare_all();                     // reset values
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);                    // IDLE holds without start

        // Basic motion: one step every STEP_DIV cycles, heading right.
        cycle(1, 0, 0, 0);
        steps_seen = 0;
        idle_cycles(4 * STEP_DIV);
        check_eq("steps_in_4_periods", steps_seen, 4);
        check_eq("run_head_x", int'(head_x), 20);
        check_eq("run_prev_x", int'(prev_x), 19);

        // Reversal ignored, then a valid turn up.
        cycle(0, 1, 2, 0);
        cycle(0, 1, 0, 0);
        wait_step();
        check_eq("turn_up_head_x", int'(head_x), 20);
        check_eq("turn_up_head_y", int'(head_y), 15);

        // Down (reversal) on the step edge itself must be ignored.
        while (m_tick != STEP_DIV - 1) cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 0);
        check_eq("rev_on_step_y", int'(head_y), 14);

        // Drive to (31,5) then wrap to (0,5).
        repeat (9) wait_step();
        cycle(0, 1, 3, 0);
        repeat (11) wait_step();
        check_eq("pre_wrap_x", int'(head_x), 31);
        check_eq("pre_wrap_y", int'(head_y), 5);
        wait_step();
        check_eq("wrap_head_x", int'(head_x), 0);
        check_eq("wrap_prev_x", int'(prev_x), 31);
        check_eq("wrap_head_y", int'(head_y), 5);

        // Collision with start on the step edge: collision wins, no step.
        while (m_tick != STEP_DIV - 1) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 1);
        check_eq("col_state", int'(state), 2);
        check_eq("col_step_en", int'(step_en), 0);
        check_eq("col_head_x", int'(head_x), 0);
        idle_cycles(2);                     // OVER holds, dir ignored below
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        check_eq("restart_state", int'(state), 0);
        check_eq("restart_head_x", int'(head_x), SX);
        check_eq("restart_head_y", int'(head_y), SY);

        // Randomized play.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 40) == 0));
        end

        // Get back to RUN, then asynchronous reset one cycle before a step.
        for (int i = 0; i < 8 && m_phase != 1; i++) cycle(1, 0, 0, 0);
        check_eq("run_before_reset", int'(state), 1);
        idle_cycles(3);
        while (m_tick != STEP_DIV - 2) cycle(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();                      // asynchronous effect mid-cycle
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        steps_seen = 0;
        idle_cycles(3 * STEP_DIV);
        check_eq("no_step_after_reset", steps_seen, 0);
        cycle(1, 0, 0, 0);
        steps_seen = 0;
        idle_cycles(STEP_DIV);
        check_eq("step_after_restart", steps_seen, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
